// File: rtl/result_checker.sv
// Store-bus result checker: compares observed stores against a preloaded table of expected stores.
// Define CHECKER_ORDER_FREE_EN to match stores by address in any order instead of strictly in sequence.
module result_checker #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int N_ENTRIES = 16,
  parameter int ERR_W     = 8,
  parameter int DUR_W     = 16,
  parameter int TIMEOUT   = 10000,
  localparam int IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic              finish,
  output logic              timeout,
  output logic [1:0]        curstate
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_RUN        = 2'd2,
    S_DONE       = 2'd3
  } state_e;

  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W:0]   TIMEOUT_V = (DUR_W+1)'(TIMEOUT);

  state_e             state_q, state_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               finish_q, finish_d;
  logic               timeout_q, timeout_d;
  logic               chk_en, chk_bad;

  // Table is not reset so a run can be repeated after rst without reloading.
  logic [ADDR_W-1:0]  tab_addr_q [N_ENTRIES];
  logic [DATA_W-1:0]  tab_data_q [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (!rst && exp_we && state_q == S_IDLE) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (exp_idx == IDX_W'(i)) begin
          tab_addr_q[i] <= exp_addr;
          tab_data_q[i] <= exp_data;
        end
      end
    end
  end

`ifdef CHECKER_ORDER_FREE_EN
  logic [N_ENTRIES-1:0] done_q, done_d, hit_oh;
  logic                 found;

  // First not-yet-done entry whose address and data both match the store.
  always_comb begin
    hit_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!found && !done_q[i] && addr == tab_addr_q[i] && data == tab_data_q[i]) begin
        hit_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  always_comb begin
    cur_addr = tab_addr_q[0];
    cur_data = tab_data_q[0];
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (ptr_q == IDX_W'(i)) begin
        cur_addr = tab_addr_q[i];
        cur_data = tab_data_q[i];
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    dur_d     = dur_q;
    finish_d  = finish_q;
    timeout_d = timeout_q;
    chk_en    = 1'b0;
    chk_bad   = 1'b0;
`ifdef CHECKER_ORDER_FREE_EN
    done_d    = done_q;
`else
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (wen && addr == tab_addr_q[0]) begin
          chk_en  = 1'b1;
          chk_bad = (data != tab_data_q[0]);
`ifdef CHECKER_ORDER_FREE_EN
          done_d[0] = 1'b1;
`else
          ptr_d = IDX_W'(1);
`endif
          if (N_ENTRIES == 1) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (wen) begin
          chk_en = 1'b1;
`ifdef CHECKER_ORDER_FREE_EN
          chk_bad = !found;
          done_d  = done_q | hit_oh;
          if (&done_d) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end
`else
          chk_bad = (addr != cur_addr) || (data != cur_data);
          if (ptr_q == LAST_IDX) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
`endif
        end
      end
      default: ;
    endcase

    // Timeout overrides any completion on the same cycle; that cycle's store is still scored.
    if (state_q == S_WAIT_FIRST || state_q == S_RUN) begin
      if (dur_q != DUR_MAX) dur_d = dur_q + DUR_W'(1);
      if ({1'b0, dur_d} == TIMEOUT_V) begin
        state_d   = S_DONE;
        finish_d  = 1'b1;
        timeout_d = 1'b1;
      end
    end

    if (chk_en && chk_bad && err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      err_q     <= '0;
      dur_q     <= '0;
      finish_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef CHECKER_ORDER_FREE_EN
      done_q    <= '0;
`else
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      dur_q     <= dur_d;
      finish_q  <= finish_d;
      timeout_q <= timeout_d;
`ifdef CHECKER_ORDER_FREE_EN
      done_q    <= done_d;
`else
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign error_num = err_q;
  assign duration  = dur_q;
  assign finish    = finish_q;
  assign timeout   = timeout_q;
  assign curstate  = state_q;

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter ADDR_W, default 30, word-address width of monitored store bus.
REQ-002 Parameter DATA_W, default 32, store data width.
REQ-003 Parameter N_ENTRIES, default 16, number of expected stores (>=1).
REQ-004 Parameter ERR_W, default 8, error counter width; DUR_W, default 16, cycle counter width.
REQ-005 Parameter TIMEOUT, default 10000, cycles in run before timeout abort.
REQ-006 clk  input  1  single clock, all logic rising-edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 exp_we  input  1  writes expected entry exp_idx; legal only in IDLE.
REQ-009 exp_idx  input  clog2(N_ENTRIES)  expected-table index.
REQ-010 exp_addr/exp_data  input  ADDR_W/DATA_W  expected store address/value.
REQ-011 start  input  1  one-cycle pulse, IDLE -> WAIT_FIRST.
REQ-012 addr/data/wen  input  ADDR_W/DATA_W/1  monitored store bus; sampled when wen=1.
REQ-013 error_num  output  ERR_W  mismatch count.
REQ-014 duration  output  DUR_W  cycles from start to finish.
REQ-015 finish  output  1  sticky done flag; timeout  output  1  sticky abort flag.
REQ-016 curstate  output  2  IDLE=0, WAIT_FIRST=1, RUN=2, DONE=3.

Function
REQ-017 Table entries SHALL be registers; exp_we outside IDLE SHALL be ignored.
REQ-018 WAIT_FIRST: stores with addr != entry0 address SHALL be ignored (no error); a store with addr == entry0 address SHALL be checked as entry 0 and move to RUN next cycle.
REQ-019 RUN (in-order mode): each wen cycle SHALL compare addr and data with entry[ptr]; any mismatch SHALL increment error_num by 1; ptr SHALL advance by 1 regardless.
REQ-020 error_num SHALL saturate at 2^ERR_W-1, never wrap.
REQ-021 When the check of entry N_ENTRIES-1 occurs, state SHALL go DONE and finish SHALL rise the following cycle.
REQ-022 N_ENTRIES=1: the WAIT_FIRST match SHALL go directly to DONE.
REQ-023 duration SHALL increment every cycle in WAIT_FIRST and RUN, freeze in DONE, saturate at 2^DUR_W-1.
REQ-024 When duration reaches TIMEOUT before DONE, state SHALL go DONE with timeout=1 and finish=1; error_num frozen.
REQ-025 Store on the same cycle as timeout SHALL still be checked; timeout takes precedence for state.
REQ-026 wen in IDLE or DONE SHALL be ignored.
REQ-027 start outside IDLE SHALL be ignored; start and wen same cycle: store ignored.
REQ-028 Checker SHALL only observe; it drives no signal back to the monitored bus.

Reset
REQ-029 rst SHALL force state IDLE, ptr 0, error_num 0, duration 0, finish 0, timeout 0, clear all per-entry done bits.
REQ-030 Table contents SHALL be retained across rst; rst mid-run SHALL abort without flagging errors.
REQ-031 rst SHALL override start, exp_we and wen in the same cycle.

Configuration
REQ-032 Macro CHECKER_ORDER_FREE_EN defined: RUN SHALL match each store by address against all not-yet-done entries; hit with equal data marks entry done; hit with unequal data or no hit increments error_num; DONE when all entries done.
REQ-033 Store to an already-done address with macro defined SHALL count as error.
REQ-034 Macro undefined: strict in-order behaviour of REQ-019; no associative logic synthesised.

Verification
REQ-035 N=4 in-order, load A0..A3/D0..D3, start, stores in order matching -> finish=1, error_num=0, duration = cycles to 4th store.
REQ-036 Stores to 0x10, 0x11 (non-matching) before entry0 -> ignored, curstate stays 1, error_num=0.
REQ-037 Store 2 data wrong, store 3 address wrong -> error_num=2, finish=1.
REQ-038 TIMEOUT=50, only 2 of 4 stores -> at duration 50 timeout=1, finish=1, duration=50 frozen.
REQ-039 ERR_W=2, 6 mismatching stores (N=8) -> error_num saturates at 3.
REQ-040 CHECKER_ORDER_FREE_EN, stores in order 0,3,1,2 matching -> error_num=0; repeat of entry 1 -> error_num=1; rst mid-run -> all outputs 0, table retained.
